pipe_stage_buf: RTL and testbench

//  Parametrised pipeline-stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_buf.sv | 107 ++++++++++
 tb/tb_pipe_stage_buf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage register with a 2-entry skid buffer, flush-to-bubble
// and a saturating stall-cycle counter. All state updates on the falling clock edge.
module pipe_stage_buf #(
  parameter int               WIDTH     = 96,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic [WIDTH-1:0] skid, skid_nxt;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push, pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign in_ready  = ready_q;
  assign occupancy = 2'(state);

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = EMPTY;
      head_nxt  = NOP_VALUE;
      skid_nxt  = NOP_VALUE;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt = ONE;
          head_nxt  = in_data;
        end
        ONE: begin
          if (push && pop) begin
            head_nxt = in_data;
          end else if (push) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (pop) begin
            state_nxt = EMPTY;
            head_nxt  = NOP_VALUE;
          end
        end
        TWO: if (pop) begin
          state_nxt = ONE;
          head_nxt  = skid;
          skid_nxt  = NOP_VALUE;
        end
        default: begin
          state_nxt = EMPTY;
          head_nxt  = NOP_VALUE;
          skid_nxt  = NOP_VALUE;
        end
      endcase
    end
  end

  // A flushed edge is not a stall, even if the head was being held.
  always_comb begin
    cnt_nxt = stall_cnt;
    if (out_valid && !out_ready && !flush) cnt_nxt = sat_inc(stall_cnt);
  end

  // in_ready comes from the next-state decode, so out_ready never reaches it combinationally.
  always_ff @(negedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state     <= EMPTY;
      head      <= NOP_VALUE;
      skid      <= NOP_VALUE;
      ready_q   <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      head      <= head_nxt;
      skid      <= skid_nxt;
      ready_q   <= (state_nxt != TWO);
      stall_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios plus randomized traffic checked against
// a queue-based model of a 2-deep FIFO stage with flush and a saturating stall counter.
module tb_pipe_stage_buf;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [95:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [95:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [95:0] mq[$];
  int unsigned m_cnt = 0;
  int unsigned m_cnt4 = 0;

  always #5 Clk = ~Clk;

  pipe_stage_buf dut (
    .Clk(Clk), .Clrn(Clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(4)) dut4 (
    .Clk(Clk), .Clrn(Clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data[7:0]), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drive one transfer cycle (inputs change on the rising edge) and advance the model.
  task automatic cycle(input logic v, input logic [95:0] d, input logic r, input logic f);
    bit rdy, vld, push, pop;
    @(posedge Clk);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    rdy  = (mq.size() < 2);
    vld  = (mq.size() != 0);
    push = v && rdy;
    pop  = vld && r;
    if (f) begin
      mq.delete();
    end else begin
      if (vld && !r) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
    @(negedge Clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge Clk);
    Clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    mq.delete(); m_cnt = 0; m_cnt4 = 0;
    @(negedge Clk);
    @(posedge Clk);
    Clrn = 1'b1;
    @(negedge Clk); #1;
  endtask

  task automatic test_reset();
    logic [95:0] a, b;
    a = rnd96(); b = rnd96();
    apply_reset();
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 96'h0 || in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 16'd0)
      $display("FAIL reset_init: v=%0b d=%h rdy=%0b occ=%0d cnt=%0d, want v=0 d=0 rdy=1 occ=0 cnt=0",
               out_valid, out_data, in_ready, occupancy, stall_cnt);
    else pass_cnt++;
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    total_cnt++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a)
      $display("FAIL reset_prefill: occ=%0d rdy=%0b d=%h, want occ=2 rdy=0 d=%h", occupancy, in_ready, out_data, a);
    else pass_cnt++;
    #2 Clrn = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 96'h0 || in_ready !== 1'b1 || occupancy !== 2'd0 || stall_cnt !== 16'd0)
      $display("FAIL reset_async: v=%0b d=%h rdy=%0b occ=%0d cnt=%0d, want v=0 d=0 rdy=1 occ=0 cnt=0",
               out_valid, out_data, in_ready, occupancy, stall_cnt);
    else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b0;
    mq.delete(); m_cnt = 0; m_cnt4 = 0;
    @(posedge Clk); Clrn = 1'b1;
    cycle(1'b1, b, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== b || occupancy !== 2'd1)
      $display("FAIL reset_release: v=%0b d=%h occ=%0d, want v=1 d=%h occ=1", out_valid, out_data, occupancy, b);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 96'(i), 1'b1, 1'b0);
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== 96'(i) || occupancy !== 2'd1 || stall_cnt !== 16'd0 || in_ready !== 1'b1)
        $display("FAIL stream_%0d: v=%0b d=%h occ=%0d cnt=%0d rdy=%0b, want v=1 d=%0d occ=1 cnt=0 rdy=1",
                 i, out_valid, out_data, occupancy, stall_cnt, in_ready, i);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [95:0] a, b, z;
    a = rnd96(); b = rnd96(); z = rnd96();
    apply_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    total_cnt++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a || out_valid !== 1'b1)
      $display("FAIL bp_full: occ=%0d rdy=%0b d=%h, want occ=2 rdy=0 d=%h", occupancy, in_ready, out_data, a);
    else pass_cnt++;
    cycle(1'b1, z, 1'b0, 1'b0);
    cycle(1'b1, z, 1'b0, 1'b0);
    total_cnt++;
    if (stall_cnt !== 16'd3 || occupancy !== 2'd2 || out_data !== a)
      $display("FAIL bp_hold: cnt=%0d occ=%0d d=%h, want cnt=3 occ=2 d=%h", stall_cnt, occupancy, out_data, a);
    else pass_cnt++;
    cycle(1'b0, z, 1'b1, 1'b0);
    total_cnt++;
    if (out_data !== b || occupancy !== 2'd1 || in_ready !== 1'b1 || stall_cnt !== 16'd3)
      $display("FAIL bp_drain_b: d=%h occ=%0d rdy=%0b cnt=%0d, want d=%h occ=1 rdy=1 cnt=3",
               out_data, occupancy, in_ready, stall_cnt, b);
    else pass_cnt++;
    cycle(1'b0, z, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 96'h0 || occupancy !== 2'd0)
      $display("FAIL bp_empty: v=%0b d=%h occ=%0d, want v=0 d=0 occ=0", out_valid, out_data, occupancy);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [95:0] a, b, c;
    a = rnd96(); b = rnd96(); c = rnd96();
    apply_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b1);
    total_cnt++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 96'h0 || in_ready !== 1'b1 || stall_cnt !== 16'd1)
      $display("FAIL flush_full: occ=%0d v=%0b d=%h rdy=%0b cnt=%0d, want occ=0 v=0 d=0 rdy=1 cnt=1",
               occupancy, out_valid, out_data, in_ready, stall_cnt);
    else pass_cnt++;
    cycle(1'b0, c, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL flush_no_c: v=%0b occ=%0d d=%h, want v=0 occ=0", out_valid, occupancy, out_data);
    else pass_cnt++;
  endtask

  task automatic test_simul();
    logic [95:0] x, y;
    x = rnd96(); y = rnd96();
    apply_reset();
    cycle(1'b1, x, 1'b0, 1'b0);
    cycle(1'b1, y, 1'b1, 1'b0);
    total_cnt++;
    if (out_data !== y || occupancy !== 2'd1 || out_valid !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL simul_push_pop: d=%h occ=%0d v=%0b rdy=%0b, want d=%h occ=1 v=1 rdy=1",
               out_data, occupancy, out_valid, in_ready, y);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [95:0] a;
    a = rnd96();
    apply_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, rnd96(), 1'b0, 1'b0);
    total_cnt++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20)
      $display("FAIL sat_cnt: cnt4=%0d cnt16=%0d, want cnt4=15 cnt16=20", stall_cnt4, stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (out_valid4 !== 1'b1 || occupancy4 !== 2'd1 || in_ready4 !== 1'b1 || out_data4 !== a[7:0])
      $display("FAIL sat_state: v=%0b occ=%0d rdy=%0b d=%h, want v=1 occ=1 rdy=1 d=%h",
               out_valid4, occupancy4, in_ready4, out_data4, a[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [119:0] got, want;
    logic [95:0]  head;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, rnd96(), ($urandom % 3) != 0, ($urandom % 16) == 0);
      head = (mq.size() != 0) ? mq[0] : 96'h0;
      want = {mq.size() != 0, mq.size() < 2, 2'(mq.size()), head, 16'(m_cnt), 4'(m_cnt4)};
      got  = {out_valid, in_ready, occupancy, out_data, stall_cnt, stall_cnt4};
      total_cnt++;
      if (got !== want)
        $display("FAIL random_%0d: {v,rdy,occ,data,cnt,cnt4} got %h want %h", i, got, want);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simul();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
